seq_alu: RTL

Execute-stage arithmetic unit downstream of the ALU control decoder: consumes the 5-bit `ALU_operation` code plus two operands and produces a registered result with a start/done handshake. Single-cycle ops complete in one clock. Shifts run iteratively at one bit per cycle unless fast shift is compiled in. The core controller stalls on `busy` and captures `result` on the `done` pulse.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/seq_shifter.sv | 115 +++++++++++
 rtl/seq_alu.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: default operand / shift-amount
// widths, the 5-bit ALU operation codes produced by ALU control, and the state
// encoding of the sequential ALU controller. Also used by ALU control and the
// core controller so that all three agree on the encodings.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SHW   = 5;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_LUI  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01010;
    localparam logic [4:0] OP_SRA  = 5'b01011;
    localparam logic [4:0] OP_SLL  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b10110;
    localparam logic [4:0] OP_SLTU = 5'b10111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

endpackage

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
// Shift engine for seq_alu. The default build is an iterative one-bit-per-cycle
// shifter: the shift register, the remaining-amount counter and the captured
// direction / arithmetic controls live here. With SEQ_ALU_FAST_SHIFT_EN
// defined the body becomes a purely combinational barrel shifter.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture d/dir/arith/amt and perform the first one-bit step
//   en          : perform one further one-bit step
//   dir         : 1 = shift left, 0 = shift right
//   arith       : right shifts fill with the sign bit
//   d, amt      : operand and shift amount
//   q           : current shift register contents
//   q_next      : value after the step taken this cycle (load or en view)
//   last        : the step taken this cycle is the final one
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             dir,
    input  logic             arith,
    input  logic [WIDTH-1:0] d,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             last
);

`ifdef SEQ_ALU_FAST_SHIFT_EN

    logic w_unused_ctl;
    assign w_unused_ctl = clk ^ reset ^ load ^ en;

    // Full barrel shift of the operand in one cycle.
    always_comb begin
        q_next = d;
        if (dir) begin
            q_next = d << amt;
        end else if (arith) begin
            q_next = $signed(d) >>> amt;
        end else begin
            q_next = d >> amt;
        end
    end

    assign q    = q_next;
    assign last = 1'b1;

`else

    localparam logic [SHW-1:0] AMT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir;
    logic             r_arith;

    logic [WIDTH-1:0] w_src;
    logic             w_dir;
    logic             w_arith;

    // On load the step is taken on the incoming operand with the incoming
    // controls, so the first bit is shifted in the accept cycle itself.
    always_comb begin
        if (load) begin
            w_src   = d;
            w_dir   = dir;
            w_arith = arith;
        end else begin
            w_src   = r_q;
            w_dir   = r_dir;
            w_arith = r_arith;
        end
        if (w_dir) begin
            q_next = {w_src[WIDTH-2:0], 1'b0};
        end else begin
            q_next = {(w_arith & w_src[WIDTH-1]), w_src[WIDTH-1:1]};
        end
    end

    // Shift register, remaining-step counter and captured controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= {WIDTH{1'b0}};
            r_cnt   <= {SHW{1'b0}};
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
        end else if (load) begin
            r_q     <= q_next;
            r_cnt   <= amt - AMT_ONE;
            r_dir   <= dir;
            r_arith <= arith;
        end else if (en) begin
            r_q     <= q_next;
            r_cnt   <= r_cnt - AMT_ONE;
        end else begin
            r_q     <= r_q;
            r_cnt   <= r_cnt;
        end
    end

    assign q    = r_q;
    // Counter holds the steps still to do; the step with one left is the last.
    assign last = (r_cnt == AMT_ONE);

`endif

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Execute-stage ALU with a start/done handshake. Single-cycle ops complete one
// clock after acceptance; shifts iterate one bit per cycle (busy high while
// iterating) unless SEQ_ALU_FAST_SHIFT_EN is defined, which makes every shift
// complete in one cycle and ties busy low.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : request, sampled only while busy is low
//   alu_op     : 5-bit operation code
//   a, b       : operands (shift amount is b[SHW-1:0])
//   busy       : a shift is iterating
//   done       : one-cycle pulse, result/zero/illegal valid
//   result     : registered result, held until next completion
//   zero       : result == 0
//   illegal    : last completed op had an unsupported code
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic             w_dir;
    logic             w_arith;
    logic             w_illegal_op;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_imm_res;

    logic             w_sh_load;
    logic             w_sh_en;
    logic [WIDTH-1:0] w_sh_next;
    logic [WIDTH-1:0] w_sh_q_unused;
    logic             w_sh_last;

    logic             w_load_out;
    logic [WIDTH-1:0] w_out_res;
    logic             w_out_ill;
    logic             w_busy_next;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    assign w_amt = b[SHW-1:0];

    // Operation decode and single-cycle datapath; unknown codes land in default.
    always_comb begin
        w_is_shift   = 1'b0;
        w_dir        = 1'b0;
        w_arith      = 1'b0;
        w_illegal_op = 1'b0;
        w_alu_res    = {WIDTH{1'b0}};
        case (alu_op)
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_LUI:  w_alu_res = b;
            OP_SRL:  w_is_shift = 1'b1;
            OP_SRA: begin
                w_is_shift = 1'b1;
                w_arith    = 1'b1;
            end
            OP_SLL: begin
                w_is_shift = 1'b1;
                w_dir      = 1'b1;
            end
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_illegal_op = 1'b1;
        endcase
    end

    // Result available at acceptance: shift amount 0 passes a; otherwise the
    // shifter's first step (amount 1 iterative, full amount in fast build).
    always_comb begin
        if (w_is_shift) begin
            if (w_amt == {SHW{1'b0}}) begin
                w_imm_res = a;
            end else begin
                w_imm_res = w_sh_next;
            end
        end else begin
            w_imm_res = w_alu_res;
        end
    end

    seq_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (w_sh_load),
        .en     (w_sh_en),
        .dir    (w_dir),
        .arith  (w_arith),
        .d      (a),
        .amt    (w_amt),
        .q      (w_sh_q_unused),
        .q_next (w_sh_next),
        .last   (w_sh_last)
    );

`ifdef SEQ_ALU_FAST_SHIFT_EN

    logic w_unused_last;
    assign w_unused_last = w_sh_last;

    // Every accepted op completes in the following cycle.
    always_comb begin
        w_load_out  = start;
        w_out_res   = w_imm_res;
        w_out_ill   = w_illegal_op;
        w_sh_load   = start & w_is_shift;
        w_sh_en     = 1'b0;
        w_busy_next = 1'b0;
    end

`else

    localparam logic [SHW-1:0] AMT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    alu_state_t r_state;
    alu_state_t w_state_next;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and datapath control. The shifter is loaded for every
    // accepted shift so its first step is available immediately; amounts 0
    // and 1 therefore finish without entering SHIFT.
    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
        w_out_res    = w_imm_res;
        w_out_ill    = w_illegal_op;
        w_sh_load    = 1'b0;
        w_sh_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_sh_load = w_is_shift;
                    if (w_is_shift && (w_amt > AMT_ONE)) begin
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_load_out   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_sh_en = 1'b1;
                if (w_sh_last) begin
                    w_load_out   = 1'b1;
                    w_out_res    = w_sh_next;
                    w_out_ill    = 1'b0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_busy_next = (w_state_next == ST_SHIFT);
    end

`endif

    // Output registers: done pulses on completion, result/zero/illegal held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= {WIDTH{1'b0}};
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_load_out;
            if (w_load_out) begin
                r_result  <= w_out_res;
                r_zero    <= (w_out_res == {WIDTH{1'b0}});
                r_illegal <= w_out_ill;
            end else begin
                r_result  <= r_result;
                r_zero    <= r_zero;
                r_illegal <= r_illegal;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;

endmodule
